mem_read_burst: RTL and testbench

Burst read sequencer sitting directly upstream of the single-word memory read controller. It converts one `start` request for `len` words into a series of `go` requests to the controller, and captures `mem_data` on each `ds` strobe into a small FIFO. The FIFO drains to the downstream consumer through a valid/ready handshake. Word issue is throttled so the FIFO can never overflow.

---
 rtl/mem_read_burst.sv | 131 +++++++++++++
 tb/tb_mem_read_burst.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_burst.sv
// Burst read sequencer: turns one start/len request into single-word go requests
// and buffers the returned words in a small FIFO. Optional watchdog: MEM_READ_BURST_TIMEOUT_EN.
module mem_read_burst #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              go,
  input  logic              rd,
  input  logic              ds,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    ISSUE   = 3'd2,
    WAIT_DS = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic              err_q;
  logic              push, pop, wd_expire;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  // Output handshake: a word transfers on any rising edge where out_valid && out_ready;
  // out_valid never depends on out_ready, and out_data holds until that transfer.
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  assign go        = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign err       = err_q;
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? HOLD : FIN;
      // Issuing only with a free slot is what keeps the FIFO from overflowing.
      HOLD:    if (count < CNT_W'(DEPTH)) state_nxt = ISSUE;
      ISSUE:   if (rd) state_nxt = WAIT_DS;
      WAIT_DS: begin
        if (ds) begin
          push      = 1'b1;
          state_nxt = (remaining == LEN_W'(1)) ? FIN : HOLD;
        end else if (wd_expire) begin
          state_nxt = FIN;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                          remaining <= '0;
    else if (state == IDLE && start)    remaining <= len;
    else if (push)                      remaining <= remaining - 1'b1;
    else if (wd_expire)                 remaining <= '0;
  end

  // A stray strobe outside WAIT_DS outranks the clear from a simultaneous start.
  always_ff @(posedge clock) begin
    if (reset)                          err_q <= 1'b0;
    else if (ds && state != WAIT_DS)    err_q <= 1'b1;
    else if (wd_expire)                 err_q <= 1'b1;
    else if (state == IDLE && start)    err_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= mem_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MEM_READ_BURST_TIMEOUT_EN
  logic [4:0] wdog;

  // Held at zero outside WAIT_DS, so every entry starts a fresh count.
  always_ff @(posedge clock) begin
    if (reset || state != WAIT_DS) wdog <= '0;
    else                           wdog <= wdog + 5'd1;
  end

  assign wd_expire = (state == WAIT_DS) && !ds && (wdog == 5'd30);
`else
  assign wd_expire = 1'b0;
`endif

endmodule

// File: tb/tb_mem_read_burst.sv
// Bench for mem_read_burst: behavioural memory controller, scoreboard of captured
// words popped by a negedge monitor, and directed plus random bursts.
module tb_mem_read_burst;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  len = '0;
  logic              go;
  logic              rd = 1'b0;
  logic              ds = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              busy, done, err;
  logic [2:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  int go_t[$];
  int done_t[$];
  int occ = 0;
  logic go_prev = 1'b0;

  bit mon_en = 1'b0, rand_mode = 1'b1, stuck = 1'b0, seq_mode = 1'b0, ds_legit = 1'b0;
  int inject_req = 0, inject_ack = 0, ctl_words = 0, seq_base = 0;
  int ctl_st = 0, ctl_dly = 0;
  int ws_cfg[64];

  mem_read_burst #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len), .go(go),
    .rd(rd), .ds(ds), .mem_data(mem_data), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1);
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Controller model: rd answers go in the same cycle, one DELAY cycle
  // (+2 per wait state), then ds with the word.
  initial forever begin
    @(posedge clock);
    #1;
    rd = 1'b0; ds = 1'b0; ds_legit = 1'b0;
    if (rand_mode) begin
      rd = 1'($urandom); ds = 1'($urandom); mem_data = 8'($urandom); ctl_st = 0;
    end else if (reset) begin
      ctl_st = 0;
    end else if (inject_req != inject_ack) begin
      ds = 1'b1;
      inject_ack = inject_req;
    end else begin
      case (ctl_st)
        0: if (go) begin
             rd = 1'b1;
             ctl_dly = 2 * ws_cfg[ctl_words % 64];
             ctl_st = 1;
           end
        1: if (ctl_dly == 0) ctl_st = stuck ? 3 : 2;
           else ctl_dly--;
        2: begin
             ds = 1'b1; ds_legit = 1'b1;
             mem_data = seq_mode ? 8'(8'hA1 + ctl_words - seq_base) : 8'($urandom);
             ctl_words++;
             ctl_st = 0;
           end
        default: ;
      endcase
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clock);
    if (!mon_en) begin
      exp_q.delete();
      occ = 0;
      go_prev = 1'b0;
    end else begin
      check("out_valid", 32'(out_valid), 32'(occ != 0));
      check("occupancy_bound", 32'(occ <= DEPTH), 1);
      if (go) check("go_fifo_gate", 32'(occ < DEPTH), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("pop_unexpected", 0, 1);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        got_q.push_back(out_data);
        occ--;
      end
      if (ds && ds_legit) begin
        exp_q.push_back(mem_data);
        occ++;
      end
      if (go && !go_prev) go_t.push_back(cyc);
      if (done) done_t.push_back(cyc);
      go_prev = go;
    end
  end

  task automatic wait_done(input int budget, input bit rnd);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (rnd) out_ready = 1'($urandom);
      tick();
      if (done) found = 1'b1;
    end
    check("done_seen", 32'(found), 1);
  endtask

  task automatic drain();
    bit empty = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && !empty; i++) begin
      tick();
      if (!out_valid && exp_q.size() == 0) empty = 1'b1;
    end
    check("drain_empty", 32'(empty), 1);
  endtask

  task automatic launch(input int n);
    len = LEN_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int g0, d0, n0, wl;
    for (int i = 0; i < 64; i++) ws_cfg[i] = 0;

    // Reset with random inputs
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom); len = LEN_W'($urandom); out_ready = 1'($urandom);
      tick();
      check("reset_outputs", 32'({go, busy, done, err, out_valid, out_data}), 0);
    end

    // start held through reset, len=3 sequential data
    start = 1'b1; len = 3; out_ready = 1'b1;
    rand_mode = 1'b0; seq_mode = 1'b1; seq_base = ctl_words;
    tick();
    check("reset_start_held", 32'(busy), 0);
    reset = 1'b0; mon_en = 1'b1;
    g0 = go_t.size(); d0 = done_t.size(); n0 = got_q.size();
    #1;
    check("busy_low_at_release", 32'(busy), 0);
    tick();
    check("busy_after_start", 32'(busy), 1);
    start = 1'b0;
    wait_done(60, 1'b0);
    check("len3_err", 32'(err), 0);
    drain();
    check("len3_go_count", 32'(go_t.size() - g0), 3);
    check("len3_done_count", 32'(done_t.size() - d0), 1);
    if (go_t.size() - g0 >= 3 && done_t.size() > d0) begin
      check("len3_go_spacing1", 32'(go_t[g0+1] - go_t[g0]), 4);
      check("len3_go_spacing2", 32'(go_t[g0+2] - go_t[g0+1]), 4);
      check("len3_done_latency", 32'(done_t[d0] - go_t[g0+2]), 3);
    end
    if (got_q.size() - n0 >= 3) begin
      check("len3_word0", 32'(got_q[n0]),   32'h A1);
      check("len3_word1", 32'(got_q[n0+1]), 32'h A2);
      check("len3_word2", 32'(got_q[n0+2]), 32'h A3);
    end
    seq_mode = 1'b0;

    // len=6 with a stalled consumer: only DEPTH words issue
    out_ready = 1'b0;
    g0 = go_t.size(); d0 = done_t.size();
    launch(6);
    repeat (40) tick();
    check("stall_go_count", 32'(go_t.size() - g0), 4);
    check("stall_go_low", 32'(go), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    wait_done(80, 1'b0);
    drain();
    check("stall_go_total", 32'(go_t.size() - g0), 6);
    check("stall_done_count", 32'(done_t.size() - d0), 1);

    // Two wait states on word 2 of a 2-word burst
    ws_cfg[(ctl_words + 1) % 64] = 2;
    g0 = go_t.size(); d0 = done_t.size();
    launch(2);
    wait_done(60, 1'b0);
    drain();
    ws_cfg[(ctl_words - 1) % 64] = 0;
    check("ws_go_count", 32'(go_t.size() - g0), 2);
    if (go_t.size() - g0 >= 2 && done_t.size() > d0) begin
      check("ws_word1_cycles", 32'(go_t[g0+1] - go_t[g0]), 4);
      check("ws_word2_done", 32'(done_t[d0] - go_t[g0+1]), 3 + 2 * 2);
    end

    // Stray ds in IDLE with one word buffered
    out_ready = 1'b0;
    launch(1);
    wait_done(30, 1'b0);
    tick();
    check("pre_inject_err", 32'(err), 0);
    inject_req++;
    tick();
    tick();
    check("idle_ds_err", 32'(err), 1);
    check("idle_ds_no_push", 32'(exp_q.size()), 1);
    check("idle_ds_busy", 32'(busy), 0);
    drain();
    launch(1);
    check("err_cleared_by_start", 32'(err), 0);
    wait_done(30, 1'b0);
    drain();

    // len=0: immediate done, no reads
    g0 = go_t.size();
    launch(0);
    check("len0_done", 32'(done), 1);
    check("len0_busy", 32'(busy), 1);
    tick();
    check("len0_done_once", 32'(done), 0);
    check("len0_idle", 32'(busy), 0);
    check("len0_no_go", 32'(go_t.size() - g0), 0);

    // Random bursts with random wait states and random consumer
    for (int k = 0; k < 6; k++) begin
      wl = $urandom_range(1, 9);
      for (int j = 0; j < wl; j++) ws_cfg[(ctl_words + j) % 64] = $urandom_range(0, 1);
      g0 = go_t.size(); d0 = done_t.size();
      launch(wl);
      wait_done(250, 1'b1);
      drain();
      for (int j = 0; j < 64; j++) ws_cfg[j] = 0;
      check("rand_go_count", 32'(go_t.size() - g0), 32'(wl));
      check("rand_done_count", 32'(done_t.size() - d0), 1);
      check("rand_err", 32'(err), 0);
    end

    // Reset mid-burst flushes the FIFO and suppresses done
    out_ready = 1'b0;
    launch(6);
    repeat (12) tick();
    reset = 1'b1; mon_en = 1'b0;
    tick();
    check("midreset_flush", 32'({go, busy, done, err, out_valid, out_data}), 0);
    reset = 1'b0; mon_en = 1'b1;
    d0 = done_t.size();
    repeat (5) tick();
    check("midreset_no_done", 32'(done_t.size() - d0), 0);
    check("midreset_idle", 32'(busy), 0);
    out_ready = 1'b1;

`ifdef MEM_READ_BURST_TIMEOUT_EN
    // Stuck controller: watchdog ends the burst
    stuck = 1'b1;
    g0 = go_t.size(); d0 = done_t.size();
    launch(2);
    wait_done(80, 1'b0);
    check("timeout_err", 32'(err), 1);
    check("timeout_go_count", 32'(go_t.size() - g0), 1);
    if (go_t.size() > g0 && done_t.size() > d0)
      check("timeout_latency", 32'(done_t[d0] - go_t[g0]), 32);
    stuck = 1'b0;
    reset = 1'b1; mon_en = 1'b0;
    tick();
    reset = 1'b0; mon_en = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
